head_slicer: RTL and testbench
==============================

HEAD_SLICER -- requirements
Module: head_slicer

Interface
REQ-001 Parameter HEAD_SLICE_NUM, default 2, number of leading beats per packet emitted as head slices (range 1..8).
REQ-002 Parameter FIFO_DEPTH, default 64, payload FIFO depth in beats (power of two).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_port  input  4  ingress port ID, sampled on each SOP beat.
REQ-007 i_valid  input  1  input beat valid.
REQ-008 o_ready  output  1  input beat accepted when i_valid & o_ready.
REQ-009 i_data  input  HEAD_WIDTH  beat data; byte 0 in MSBs.
REQ-010 i_sop / i_eop  input  1 each  first / last beat of packet.
REQ-011 i_bcnt  input  7  valid bytes in beat (1..64), meaningful on EOP only.
REQ-012 o_head  output  HEAD_WIDTH+TAG_WIDTH  head slice with tag, no backpressure.
REQ-013 o_meta  output  META_WIDTH+TAG_WIDTH  meta slice with tag, no backpressure.
REQ-014 o_pl_valid / i_pl_ready  output / input  1 each  payload stream handshake.
REQ-015 o_pl_data, o_pl_sop, o_pl_eop, o_pl_bcnt, o_pl_id  outputs  HEAD_WIDTH, 1, 1, 7, 16  payload beat and sideband.
REQ-016 o_err  output  1  one-cycle pulse on framing error.

Function
REQ-017 HEAD_WIDTH 512, byte width 64; tag = {VALID, SHIFT, TAIL, START, OFFSET[5:0]}.
REQ-018 FSM states IDLE, HEAD, BODY; IDLE->HEAD on accepted SOP without EOP; HEAD->BODY when accepted slice count reaches HEAD_SLICE_NUM without EOP; HEAD or BODY->IDLE on accepted EOP; SOP+EOP in IDLE stays IDLE.
REQ-019 Each accepted beat in slice positions 0..HEAD_SLICE_NUM-1 drives o_head one cycle later: VALID=1, SHIFT=1, START=(position 0), TAIL=(last position or EOP), OFFSET=EOP ? bcnt-1 : 63.
REQ-020 Beats in BODY never appear on o_head; o_head VALID=0 in any cycle without a new head slice.
REQ-021 o_meta asserted in the same cycle as the START head slice: fields {pkt_id[15:0], port[3:0]} in MSBs, rest zero; tag VALID=SHIFT=START=TAIL=1, OFFSET=META_WIDTH/8-1.
REQ-022 pkt_id is a 16-bit counter, incremented per accepted SOP, wrapping 0xFFFF->0x0000.
REQ-023 Every accepted beat (head and body) is written to the payload FIFO with sop, eop, bcnt, pkt_id.
REQ-024 o_ready = FIFO occupancy < FIFO_DEPTH; simultaneous write and read at full is not permitted (ready deasserted).
REQ-025 Payload output is first-word-fall-through; beat retires on o_pl_valid & i_pl_ready; o_pl_* held stable while valid & !ready.
REQ-026 SOP accepted in HEAD/BODY: o_err pulses, previous packet closed in FIFO as-is (no fabricated EOP), new packet starts at position 0.
REQ-027 Non-SOP beat accepted in IDLE: o_err pulses, beat dropped (not written, no head output).
REQ-028 Head/meta latency 1 cycle from acceptance; payload latency min 1 cycle from acceptance.

Reset
REQ-029 Reset: FSM=IDLE, slice count=0, pkt_id=0, FIFO empty, o_ready=0 during reset then 1, o_pl_valid=0, o_head and o_meta all zero, o_err=0.
REQ-030 Reset mid-packet discards the partial packet and all FIFO contents; no head/meta emitted for it.

Structure
REQ-031 HEAD_WIDTH, META_WIDTH, TAG_WIDTH, tag bit positions, meta field positions in parser_pkg.
REQ-032 Payload storage in one sub-module sync_fifo (parameterized width/depth, FWFT, count output).

Verification
REQ-033 Single 3-beat packet, port 5, EOP bcnt 10 -> two head slices (START/TAIL on 2nd, OFFSET 63,63), meta id 0 port 5, 3 payload beats, last bcnt 10.
REQ-034 1-beat packet SOP+EOP bcnt 1 -> one head slice START=TAIL=1, OFFSET 0; FSM stays IDLE.
REQ-035 i_pl_ready=0 and 64 beats accepted -> o_ready=0 on cycle after 64th; releasing ready drains 64 beats in order, o_ready returns 1.
REQ-036 SOP during BODY -> o_err pulse one cycle, new meta id+1, new START slice.
REQ-037 0x10000 packets -> pkt_id wraps, 65537th meta id 0x0000.
REQ-038 Reset asserted during 2nd beat -> all outputs zero next cycle, FIFO empty, next packet id 0.

Source files
------------

// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// Package     : parser_pkg
// Description : Widths, tag bit positions, meta field positions and FSM
//               state type shared by the head slicer and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package parser_pkg;

    localparam int HEAD_WIDTH  = 512;
    localparam int BYTE_NUM    = 64;
    localparam int META_WIDTH  = 64;
    localparam int TAG_WIDTH   = 10;

    // Tag layout: {VALID, SHIFT, TAIL, START, OFFSET[5:0]}
    localparam int TAG_VALID   = 9;
    localparam int TAG_SHIFT   = 8;
    localparam int TAG_TAIL    = 7;
    localparam int TAG_START   = 6;
    localparam int TAG_OFF_MSB = 5;

    // Meta layout: {pkt_id[15:0], port[3:0], zero padding}
    localparam int META_ID_MSB   = META_WIDTH - 1;
    localparam int META_ID_LSB   = META_WIDTH - 16;
    localparam int META_PORT_MSB = META_WIDTH - 17;
    localparam int META_PORT_LSB = META_WIDTH - 20;
    localparam int META_PAD      = META_WIDTH - 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } slicer_state_t;

    // Builds a valid, shifting tag; VALID and SHIFT are always set when emitted.
    function automatic logic [TAG_WIDTH-1:0] make_tag(input logic tail,
                                                      input logic start,
                                                      input logic [TAG_OFF_MSB:0] offset);
        return {1'b1, 1'b1, tail, start, offset};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with occupancy
//               count. Writes at full and reads at empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int           AW   = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en & (count != FULL);
    assign do_rd   = rd_en & (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/head_slicer.sv
`default_nettype none
// ============================================================================
// Module      : head_slicer
// Description : Emits the first HEAD_SLICE_NUM beats of each packet as tagged
//               head slices plus one meta slice, and forwards every accepted
//               beat through a payload FIFO with packet sideband.
// Revision    : 1.0 - initial release
// ============================================================================
module head_slicer
    import parser_pkg::*;
#(
    parameter int HEAD_SLICE_NUM = 2,
    parameter int FIFO_DEPTH     = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [3:0]                      i_port,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [HEAD_WIDTH-1:0]           i_data,
    input  logic                            i_sop,
    input  logic                            i_eop,
    input  logic [6:0]                      i_bcnt,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
    output logic                            o_pl_valid,
    input  logic                            i_pl_ready,
    output logic [HEAD_WIDTH-1:0]           o_pl_data,
    output logic                            o_pl_sop,
    output logic                            o_pl_eop,
    output logic [6:0]                      o_pl_bcnt,
    output logic [15:0]                     o_pl_id,
    output logic                            o_err
);

    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int              PW       = HEAD_WIDTH + 16 + 7 + 2;
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]      LAST_POS = 4'(HEAD_SLICE_NUM - 1);
    localparam logic [5:0]      META_OFF = 6'(META_WIDTH / 8 - 1);

    slicer_state_t state;
    logic [3:0]    slice_cnt;
    logic [15:0]   pkt_id;
    logic [15:0]   cur_id;

    logic          accept;
    logic          start_pkt;
    logic          cont_beat;
    logic          drop_beat;
    logic          emit_head;
    logic          fifo_wr;
    logic          err_now;
    logic [3:0]    pos;
    logic [5:0]    beat_off;
    logic [15:0]   wr_id;

    logic [CW-1:0] fifo_count;
    logic [PW-1:0] fifo_rd;
    logic          pl_sop;
    logic          pl_eop;
    logic [6:0]    pl_bcnt;
    logic [15:0]   pl_id;
    logic [HEAD_WIDTH-1:0] pl_data;

    assign o_ready   = ~i_rst & (fifo_count != FULL_CNT);
    assign accept    = i_valid & o_ready;
    assign start_pkt = accept & i_sop;
    assign cont_beat = accept & ~i_sop & (state != ST_IDLE);
    assign drop_beat = accept & ~i_sop & (state == ST_IDLE);
    assign pos       = start_pkt ? 4'd0 : slice_cnt;
    assign emit_head = start_pkt | (cont_beat & (state == ST_HEAD));
    assign fifo_wr   = start_pkt | cont_beat;
    assign wr_id     = start_pkt ? pkt_id : cur_id;
    assign err_now   = (start_pkt & (state != ST_IDLE)) | drop_beat;
    // bcnt of 64 wraps to 0 in six bits, so subtracting one lands on 63.
    assign beat_off  = i_eop ? (i_bcnt[5:0] - 6'd1) : 6'd63;

    // Framing FSM with registered head, meta and error outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            slice_cnt <= '0;
            pkt_id    <= '0;
            cur_id    <= '0;
            o_head    <= '0;
            o_meta    <= '0;
            o_err     <= 1'b0;
        end else begin
            o_head <= '0;
            o_meta <= '0;
            o_err  <= err_now;
            if (emit_head) begin
                o_head    <= {i_data, make_tag((pos == LAST_POS) | i_eop, pos == 4'd0, beat_off)};
                slice_cnt <= pos + 4'd1;
                if (i_eop)                state <= ST_IDLE;
                else if (pos == LAST_POS) state <= ST_BODY;
                else                      state <= ST_HEAD;
            end else if (cont_beat && i_eop) begin
                state <= ST_IDLE;
            end
            if (fifo_wr && i_eop) begin
                slice_cnt <= '0;
            end
            if (start_pkt) begin
                o_meta <= {pkt_id, i_port, {META_PAD{1'b0}}, make_tag(1'b1, 1'b1, META_OFF)};
                pkt_id <= pkt_id + 16'd1;
                cur_id <= pkt_id;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_payload_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (fifo_wr),
        .wr_data ({i_sop, i_eop, i_bcnt, wr_id, i_data}),
        .rd_en   (o_pl_valid & i_pl_ready),
        .rd_data (fifo_rd),
        .count   (fifo_count)
    );

    assign {pl_sop, pl_eop, pl_bcnt, pl_id, pl_data} = fifo_rd;
    assign o_pl_valid = (fifo_count != '0);
    // Sideband is forced to zero when empty so stale storage never shows.
    assign o_pl_data  = o_pl_valid ? pl_data : '0;
    assign o_pl_sop   = o_pl_valid & pl_sop;
    assign o_pl_eop   = o_pl_valid & pl_eop;
    assign o_pl_bcnt  = o_pl_valid ? pl_bcnt : 7'd0;
    assign o_pl_id    = o_pl_valid ? pl_id : 16'd0;

endmodule
`default_nettype wire

// File: tb/tb_head_slicer.sv
`default_nettype none
// ============================================================================
// Module      : tb_head_slicer
// Description : Self-checking bench for head_slicer: directed vector table,
//               hand sequences for fill/reset/id wrap, randomized traffic
//               checked by a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_head_slicer;

    localparam int N     = 2;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [3:0]   i_port;
    logic         i_valid;
    logic         o_ready;
    logic [511:0] i_data;
    logic         i_sop;
    logic         i_eop;
    logic [6:0]   i_bcnt;
    logic [521:0] o_head;
    logic [73:0]  o_meta;
    logic         o_pl_valid;
    logic         i_pl_ready;
    logic [511:0] o_pl_data;
    logic         o_pl_sop;
    logic         o_pl_eop;
    logic [6:0]   o_pl_bcnt;
    logic [15:0]  o_pl_id;
    logic         o_err;

    int errors = 0;
    int checks = 0;

    head_slicer #(.HEAD_SLICE_NUM(N), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_port(i_port), .i_valid(i_valid),
        .o_ready(o_ready), .i_data(i_data), .i_sop(i_sop), .i_eop(i_eop),
        .i_bcnt(i_bcnt), .o_head(o_head), .o_meta(o_meta),
        .o_pl_valid(o_pl_valid), .i_pl_ready(i_pl_ready), .o_pl_data(o_pl_data),
        .o_pl_sop(o_pl_sop), .o_pl_eop(o_pl_eop), .o_pl_bcnt(o_pl_bcnt),
        .o_pl_id(o_pl_id), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    typedef struct {
        logic         sop;
        logic         eop;
        logic [6:0]   bcnt;
        logic [15:0]  id;
        logic [511:0] data;
    } pl_t;

    pl_t          plq[$];
    bit           armed = 0;
    bit           m_in  = 0;
    int           m_pos = 0;
    logic [15:0]  m_id  = 0;
    logic [15:0]  m_cur = 0;
    logic [521:0] exp_head = '0;
    logic [73:0]  exp_meta = '0;
    logic         exp_err  = 1'b0;

    always @(negedge clk) begin
        int  occ;
        pl_t p;
        occ = plq.size();
        if (armed) begin
            check("mon_head", o_head, exp_head);
            check("mon_meta", o_meta, exp_meta);
            check("mon_err", o_err, exp_err);
            check("mon_ready", o_ready, !i_rst && (occ < DEPTH));
            check("mon_pl_valid", o_pl_valid, occ != 0);
            if (!i_rst && o_pl_valid && i_pl_ready && occ != 0) begin
                p = plq.pop_front();
                check("mon_payload", {o_pl_sop, o_pl_eop, o_pl_bcnt, o_pl_id, o_pl_data},
                      {p.sop, p.eop, p.bcnt, p.id, p.data});
            end
        end
        exp_head = '0;
        exp_meta = '0;
        exp_err  = 1'b0;
        if (i_rst) begin
            plq.delete();
            m_in  = 0;
            m_pos = 0;
            m_id  = 0;
            armed = 1;
        end else if (armed && i_valid && occ < DEPTH) begin
            bit keep;
            keep = 1;
            if (i_sop) begin
                if (m_in) exp_err = 1'b1;
                m_in  = 1;
                m_pos = 0;
                m_cur = m_id;
                exp_meta = {m_id, i_port, 44'd0, 10'h3C7};
                m_id  = m_id + 16'd1;
            end else if (!m_in) begin
                exp_err = 1'b1;
                keep    = 0;
            end else begin
                m_pos++;
            end
            if (keep) begin
                p.sop = i_sop; p.eop = i_eop; p.bcnt = i_bcnt; p.id = m_cur; p.data = i_data;
                plq.push_back(p);
                if (m_pos < N)
                    exp_head = {i_data, 1'b1, 1'b1, (m_pos == N-1) || i_eop, m_pos == 0,
                                i_eop ? 6'(i_bcnt - 7'd1) : 6'd63};
                if (i_eop) m_in = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic sop, input logic eop, input logic [6:0] bcnt,
                             input logic [3:0] port, input logic [511:0] data);
        int k;
        i_valid = 1'b1; i_sop = sop; i_eop = eop; i_bcnt = bcnt; i_port = port; i_data = data;
        k = 0;
        while (!o_ready && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (!o_ready) check("send_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 400 && o_pl_valid; k++) begin
            @(posedge clk); #1;
        end
        check("drain_timeout", o_pl_valid, 1'b0);
    endtask

    typedef struct {
        logic        sop, eop;
        logic [6:0]  bcnt;
        logic [3:0]  port;
        logic        hv, st, tl;
        logic [5:0]  off;
        logic        mv;
        logic [15:0] mid;
        logic        er;
    } vec_t;

    vec_t vecs[13];

    // Random traffic generator state
    int           rem = 0;
    bit           have = 0;
    bit           rdy_s;

    task automatic gen_beat();
        int len;
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
        i_data = d;
        i_bcnt = 7'($urandom_range(1, 64));
        i_port = 4'($urandom_range(0, 15));
        if (rem == 0 && $urandom_range(0, 15) == 0) begin
            i_sop = 1'b0; i_eop = 1'($urandom_range(0, 1));
        end else if (rem == 0 || $urandom_range(0, 19) == 0) begin
            len = $urandom_range(1, 5);
            i_sop = 1'b1; i_eop = (len == 1); rem = len - 1;
        end else begin
            rem--;
            i_sop = 1'b0; i_eop = (rem == 0);
        end
    endtask

    initial begin
        logic [9:0] etag;
        int drained;

        vecs[0]  = '{1,0, 0,5, 1,1,0,63, 1,16'd0,0};
        vecs[1]  = '{0,0, 0,5, 1,0,1,63, 0,16'd0,0};
        vecs[2]  = '{0,1,10,5, 0,0,0, 0, 0,16'd0,0};
        vecs[3]  = '{1,1, 1,9, 1,1,1, 0, 1,16'd1,0};
        vecs[4]  = '{0,0, 0,9, 0,0,0, 0, 0,16'd0,1};
        vecs[5]  = '{1,0, 0,3, 1,1,0,63, 1,16'd2,0};
        vecs[6]  = '{0,1,64,3, 1,0,1,63, 0,16'd0,0};
        vecs[7]  = '{1,0, 0,4, 1,1,0,63, 1,16'd3,0};
        vecs[8]  = '{0,0, 0,4, 1,0,1,63, 0,16'd0,0};
        vecs[9]  = '{0,0, 0,4, 0,0,0, 0, 0,16'd0,0};
        vecs[10] = '{1,0, 0,6, 1,1,0,63, 1,16'd4,1};
        vecs[11] = '{0,1,20,6, 1,0,1,19, 0,16'd0,0};
        vecs[12] = '{1,1,33,2, 1,1,1,32, 1,16'd5,0};

        i_rst = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_bcnt = 7'd0;
        i_port = 4'd0; i_data = '0; i_pl_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_head", o_head, '0);
        check("rst_meta", o_meta, '0);
        check("rst_err", o_err, 1'b0);
        check("rst_pl_valid", o_pl_valid, 1'b0);
        check("rst_ready_low", o_ready, 1'b0);
        i_rst = 1'b0;
        #1;
        check("rst_ready_high", o_ready, 1'b1);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            logic [511:0] d;
            d = {16{32'hA000_0000 + 32'(i)}};
            send_beat(vecs[i].sop, vecs[i].eop, vecs[i].bcnt, vecs[i].port, d);
            etag = vecs[i].hv ? {1'b1, 1'b1, vecs[i].tl, vecs[i].st, vecs[i].off} : 10'd0;
            check($sformatf("vec%0d_tag", i), o_head[9:0], etag);
            if (vecs[i].hv) check($sformatf("vec%0d_hdata", i), o_head[521:10], d);
            check($sformatf("vec%0d_meta", i), {o_meta[9], o_meta[73:54]},
                  vecs[i].mv ? {1'b1, vecs[i].mid, vecs[i].port} : 21'd0);
            check($sformatf("vec%0d_err", i), o_err, vecs[i].er);
        end
        wait_empty();

        // Fill the payload FIFO with the output stalled, then drain it
        i_pl_ready = 1'b0;
        for (int b = 0; b < DEPTH; b++)
            send_beat(b == 0, b == DEPTH-1, 7'd64, 4'd1, {16{32'(b)}});
        check("full_ready_low", o_ready, 1'b0);
        i_pl_ready = 1'b1;
        drained = 0;
        for (int k = 0; k < 200 && o_pl_valid; k++) begin
            drained++;
            @(posedge clk); #1;
        end
        check("full_drained", drained, DEPTH);
        check("full_ready_back", o_ready, 1'b1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rdy_s = o_ready;
            @(posedge clk); #1;
            if (i_valid && rdy_s) have = 0;
            if (!have && $urandom_range(0, 4) != 0) begin
                gen_beat();
                have = 1;
            end
            i_valid    = have;
            i_pl_ready = ($urandom_range(0, 3) != 0);
        end
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_pl_ready = 1'b1;
        wait_empty();

        // Reset during the second beat of a packet
        send_beat(1'b1, 1'b0, 7'd0, 4'd7, {16{32'h1234_5678}});
        i_valid = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_head", o_head, '0);
        check("midrst_meta", o_meta, '0);
        check("midrst_err", o_err, 1'b0);
        check("midrst_pl_valid", o_pl_valid, 1'b0);
        check("midrst_ready", o_ready, 1'b0);
        i_rst = 1'b0; i_valid = 1'b0;
        #1;
        check("midrst_ready_back", o_ready, 1'b1);
        send_beat(1'b1, 1'b1, 7'd5, 4'd8, {16{32'hCAFE_0001}});
        check("midrst_next_id", {o_meta[9], o_meta[73:58]}, {1'b1, 16'h0000});
        wait_empty();

        // Packet id wrap across 0x10000 single-beat packets
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        i_valid = 1'b1; i_sop = 1'b1; i_eop = 1'b1; i_bcnt = 7'd1; i_port = 4'd2;
        i_data = {16{32'h5A5A_A5A5}};
        for (int k = 0; k <= 65536; k++) begin
            @(posedge clk); #1;
            if (k == 65535) check("wrap_id_ffff", {o_meta[9], o_meta[73:58]}, {1'b1, 16'hFFFF});
            if (k == 65536) check("wrap_id_0000", {o_meta[9], o_meta[73:58]}, {1'b1, 16'h0000});
        end
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        wait_empty();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
